// File: rtl/konane_auto_player.sv
// Self-play master for the konane engine: picks pieces and landing cells over the op/re channels.
// Optional KONANE_RAND_PICK_EN: LFSR-driven rotating pick start instead of strict lowest-index.
module konane_auto_player #(
  parameter logic [35:0] INIT_SELECTABLE = 36'h004001004,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_multi_jump,
  input  logic              op_ready,
  output logic              op_valid,
  output logic [4:0]        op_i,
  output logic [4:0]        op_j,
  output logic              re_ready,
  input  logic              re_valid,
  input  logic              re_is_finished,
  input  logic              re_next_player_id,
  input  logic              re_player_can_giveup,
  input  logic [35:0]       re_selectable,
  output logic [CNT_W-1:0]  move_count,
  output logic [CNT_W-1:0]  games_played,
  output logic              game_done,
  output logic              last_winner
);

  localparam int unsigned N_CELLS     = 36;
  localparam logic [35:0] INIT_SHADOW = 36'hFFFFF3FFF;
  localparam logic        BLACK       = 1'b0;
  localparam logic [4:0]  GIVEUP      = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE, S_PICK, S_OP_PIECE, S_RE_PIECE, S_OP_DEST, S_RE_JUMP, S_OP_GIVEUP
  } state_e;

  state_e            state_q, state_d;
  logic              op_valid_q, op_valid_d, re_ready_q, re_ready_d;
  logic [4:0]        op_i_q, op_i_d, op_j_q, op_j_d;
  logic [5:0]        piece_q, piece_d, dest_q, dest_d;
  logic [35:0]       shadow_q, shadow_d, sel_q, sel_d;
  logic              mover_q, mover_d, winner_q, winner_d, done_q, done_d;
  logic [CNT_W-1:0]  mc_q, mc_d, gp_q, gp_d;
  logic [5:0]        off, pidx, mid;
  logic              op_fire, re_fire;

  // First set bit at or above off, wrapping; 0 when the mask is empty.
  function automatic logic [5:0] pick(input logic [35:0] mask, input logic [5:0] start);
    logic [5:0] res;
    logic       found;
    int         idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(N_CELLS); k++) begin
      idx = int'(start) + k;
      if (idx >= int'(N_CELLS)) idx = idx - int'(N_CELLS);
      if (!found && mask[6'(idx)]) begin
        res   = 6'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [35:0] reach(input logic [5:0] p);
    logic [5:0]  r, c;
    logic [35:0] m;
    r = p / 6'd6;
    c = p % 6'd6;
    m = '0;
    if (r >= 6'd2) m[p - 6'd12] = 1'b1;
    if (r <= 6'd3) m[p + 6'd12] = 1'b1;
    if (c >= 6'd2) m[p - 6'd2]  = 1'b1;
    if (c <= 6'd3) m[p + 6'd2]  = 1'b1;
    return m;
  endfunction

`ifdef KONANE_RAND_PICK_EN
  logic [5:0] lfsr_q;

  // x^6 + x^5 + 1 maximal-length sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 6'h2D;
    else        lfsr_q <= {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  end

  assign off = (lfsr_q >= 6'd36) ? lfsr_q - 6'd36 : lfsr_q;
`else
  assign off = 6'd0;
`endif

  assign op_fire = op_valid_q & op_ready;
  assign re_fire = re_ready_q & re_valid;
  assign mid     = 6'((7'(piece_q) + 7'(dest_q)) >> 1);

  always_comb begin
    state_d  = state_q;
    op_i_d   = op_i_q;
    op_j_d   = op_j_q;
    piece_d  = piece_q;
    dest_d   = dest_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    mover_d  = mover_q;
    mc_d     = mc_q;
    gp_d     = gp_q;
    winner_d = winner_q;
    done_d   = 1'b0;
    pidx     = '0;
    case (state_q)
      S_IDLE: if (enable) state_d = S_PICK;
      S_PICK: begin
        pidx    = pick(sel_q, off);
        piece_d = pidx;
        op_i_d  = 5'(pidx / 6'd6);
        op_j_d  = 5'(pidx % 6'd6);
        state_d = S_OP_PIECE;
      end
      S_OP_PIECE: if (op_fire) state_d = S_RE_PIECE;
      S_RE_PIECE: if (re_fire) begin
        pidx    = pick(re_selectable & ~shadow_q & reach(piece_q), off);
        dest_d  = pidx;
        op_i_d  = 5'(pidx / 6'd6);
        op_j_d  = 5'(pidx % 6'd6);
        state_d = S_OP_DEST;
      end
      S_OP_DEST: if (op_fire) begin
        shadow_d[piece_q] = 1'b0;
        shadow_d[mid]     = 1'b0;
        shadow_d[dest_q]  = 1'b1;
        mc_d              = mc_q + CNT_W'(1);
        state_d           = S_RE_JUMP;
      end
      S_RE_JUMP: if (re_fire) begin
        if (re_is_finished) begin
          done_d   = 1'b1;
          winner_d = mover_q;
          gp_d     = gp_q + CNT_W'(1);
          mc_d     = '0;
          shadow_d = INIT_SHADOW;
          sel_d    = INIT_SELECTABLE;
          mover_d  = BLACK;
          state_d  = enable ? S_PICK : S_IDLE;
        end else if (re_player_can_giveup) begin
          if (cfg_multi_jump && (re_selectable != '0)) begin
            pidx    = pick(re_selectable, off);
            piece_d = dest_q;
            dest_d  = pidx;
            op_i_d  = 5'(pidx / 6'd6);
            op_j_d  = 5'(pidx % 6'd6);
            state_d = S_OP_DEST;
          end else begin
            op_i_d  = GIVEUP;
            op_j_d  = GIVEUP;
            state_d = S_OP_GIVEUP;
          end
        end else begin
          mover_d = re_next_player_id;
          sel_d   = re_selectable;
          state_d = S_PICK;
        end
      end
      S_OP_GIVEUP: if (op_fire) state_d = S_RE_JUMP;
      default: state_d = S_IDLE;
    endcase
    op_valid_d = (state_d == S_OP_PIECE) || (state_d == S_OP_DEST) || (state_d == S_OP_GIVEUP);
    re_ready_d = (state_d == S_RE_PIECE) || (state_d == S_RE_JUMP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_valid_q <= 1'b0;
      re_ready_q <= 1'b0;
      op_i_q     <= '0;
      op_j_q     <= '0;
      piece_q    <= '0;
      dest_q     <= '0;
      shadow_q   <= INIT_SHADOW;
      sel_q      <= INIT_SELECTABLE;
      mover_q    <= BLACK;
      mc_q       <= '0;
      gp_q       <= '0;
      winner_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_valid_q <= op_valid_d;
      re_ready_q <= re_ready_d;
      op_i_q     <= op_i_d;
      op_j_q     <= op_j_d;
      piece_q    <= piece_d;
      dest_q     <= dest_d;
      shadow_q   <= shadow_d;
      sel_q      <= sel_d;
      mover_q    <= mover_d;
      mc_q       <= mc_d;
      gp_q       <= gp_d;
      winner_q   <= winner_d;
      done_q     <= done_d;
    end
  end

  assign op_valid     = op_valid_q;
  assign re_ready     = re_ready_q;
  assign op_i         = op_i_q;
  assign op_j         = op_j_q;
  assign move_count   = mc_q;
  assign games_played = gp_q;
  assign game_done    = done_q;
  assign last_winner  = winner_q;

endmodule

// File: tb/tb_konane_auto_player.sv
// Bench for konane_auto_player: scripted engine responses with an op scoreboard.
module tb_konane_auto_player;

  logic        clk = 1'b0;
  logic        rst_n, enable, cfg_multi_jump, op_ready;
  logic        op_valid, re_ready, re_valid;
  logic [4:0]  op_i, op_j;
  logic        re_is_finished, re_next_player_id, re_player_can_giveup;
  logic [35:0] re_selectable;
  logic [7:0]  move_count, games_played;
  logic        game_done, last_winner;

  always #5 clk = ~clk;

  konane_auto_player dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_multi_jump(cfg_multi_jump),
    .op_ready(op_ready), .op_valid(op_valid), .op_i(op_i), .op_j(op_j),
    .re_ready(re_ready), .re_valid(re_valid), .re_is_finished(re_is_finished),
    .re_next_player_id(re_next_player_id), .re_player_can_giveup(re_player_can_giveup),
    .re_selectable(re_selectable), .move_count(move_count), .games_played(games_played),
    .game_done(game_done), .last_winner(last_winner)
  );

  localparam logic [35:0] S0 = 36'hFFFFF3FFF;
  localparam logic [35:0] S1 = 36'hFFFFF7EFB;
  localparam logic [35:0] S2 = 36'hFFFFCFEFB;
  localparam logic [35:0] S3 = 36'hFFFFC3EFB;
  localparam logic [35:0] S4 = 36'hFFFEF3EFB;
  localparam logic [35:0] B1 = 36'h1;

  typedef struct {
    logic [4:0]  oi, oj;
    int          stall;
    logic        multi, en, fin, nxt, gu;
    logic [35:0] sel;
    logic [7:0]  mc;
    logic [35:0] shd;
    logic        win;
    logic [7:0]  gp;
  } step_t;

  typedef struct { logic [4:0] i, j; } op_t;

  localparam int NS = 9;
  step_t steps [NS];
  op_t   sb [$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int stall);
    int         n;
    op_t        e;
    logic [4:0] hi, hj;
    n = 0;
    while (op_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("op_valid_seen", 64'(op_valid), 64'd1);
    if (op_valid !== 1'b1) return;
    chk("re_ready_low_during_op", 64'(re_ready), 64'd0);
    hi = op_i;
    hj = op_j;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", 64'(op_valid), 64'd1);
      chk("stall_op_stable", 64'({op_i, op_j}), 64'({hi, hj}));
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got op (%0d,%0d) expected none", op_i, op_j);
    end else begin
      e = sb.pop_front();
      chk("op_i", 64'(op_i), 64'(e.i));
      chk("op_j", 64'(op_j), 64'(e.j));
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    chk("op_valid_drop", 64'(op_valid), 64'd0);
  endtask

  task automatic do_re(input step_t s);
    int n;
    n = 0;
    while (re_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("re_ready_seen", 64'(re_ready), 64'd1);
    chk("move_count", 64'(move_count), 64'(s.mc));
    chk("shadow", 64'(dut.shadow_q), 64'(s.shd));
    re_valid             = 1'b1;
    re_is_finished       = s.fin;
    re_next_player_id    = s.nxt;
    re_player_can_giveup = s.gu;
    re_selectable        = s.sel;
    @(posedge clk); #1;
    re_valid = 1'b0;
    if (s.fin) begin
      chk("game_done_pulse", 64'(game_done), 64'd1);
      chk("last_winner", 64'(last_winner), 64'(s.win));
      chk("games_played", 64'(games_played), 64'(s.gp));
      chk("move_count_cleared", 64'(move_count), 64'd0);
      chk("shadow_reinit", 64'(dut.shadow_q), 64'(S0));
      @(posedge clk); #1;
      chk("game_done_one_cycle", 64'(game_done), 64'd0);
    end else begin
      chk("game_done_quiet", 64'(game_done), 64'd0);
    end
  endtask

  initial begin
    step_t t;
    rst_n = 1'b0; enable = 1'b0; cfg_multi_jump = 1'b0; op_ready = 1'b0;
    re_valid = 1'b0; re_is_finished = 1'b0; re_next_player_id = 1'b0;
    re_player_can_giveup = 1'b0; re_selectable = '0;

    //            oi     oj     st mu en fi nx gu sel                            mc    shd win gp
    steps[0] = '{5'd0,  5'd2,  5, 0, 1, 0, 0, 0, (B1<<14)|(B1<<0)|(B1<<20),   8'd0, S0, 0, 8'd0};
    steps[1] = '{5'd2,  5'd2,  0, 0, 1, 0, 0, 1, (B1<<26),                    8'd1, S1, 0, 8'd0};
    steps[2] = '{5'd31, 5'd31, 0, 0, 1, 0, 1, 0, (B1<<17)|(B1<<30),           8'd1, S1, 0, 8'd0};
    steps[3] = '{5'd2,  5'd5,  0, 0, 1, 0, 0, 0, (B1<<15)|(B1<<29)|(B1<<5),   8'd1, S1, 0, 8'd0};
    steps[4] = '{5'd2,  5'd3,  3, 1, 1, 0, 0, 1, (B1<<13),                    8'd2, S2, 0, 8'd0};
    steps[5] = '{5'd2,  5'd1,  0, 1, 1, 1, 0, 0, 36'd0,                       8'd3, S3, 1, 8'd1};
    steps[6] = '{5'd0,  5'd2,  0, 1, 1, 0, 0, 0, (B1<<14),                    8'd0, S0, 0, 8'd1};
    steps[7] = '{5'd2,  5'd2,  0, 1, 1, 0, 0, 1, (B1<<26),                    8'd1, S1, 0, 8'd1};
    steps[8] = '{5'd4,  5'd2,  0, 1, 0, 1, 0, 0, 36'd0,                       8'd2, S4, 0, 8'd2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_re_ready", 64'(re_ready), 64'd0);
    chk("rst_op_ij", 64'({op_i, op_j}), 64'd0);
    chk("rst_move_count", 64'(move_count), 64'd0);
    chk("rst_games_played", 64'(games_played), 64'd0);
    chk("rst_done_winner", 64'({game_done, last_winner}), 64'd0);
    chk("rst_shadow", 64'(dut.shadow_q), 64'(S0));
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_op", 64'(op_valid), 64'd0);

    enable = 1'b1;
    sb.push_back('{steps[0].oi, steps[0].oj});
    for (int k = 0; k < NS; k++) begin
      cfg_multi_jump = steps[k].multi;
      enable         = steps[k].en;
      do_op(steps[k].stall);
      do_re(steps[k]);
      if (k + 1 < NS) sb.push_back('{steps[k+1].oi, steps[k+1].oj});
    end

    // enable low at game end must park the FSM in idle
    repeat (10) begin
      @(posedge clk); #1;
      chk("parked_idle", 64'({op_valid, re_ready}), 64'd0);
    end

    // mid-game reset clears counters and board immediately
    enable = 1'b1;
    cfg_multi_jump = 1'b0;
    sb.push_back('{5'd0, 5'd2});
    do_op(0);
    t = '{5'd0, 5'd2, 0, 0, 1, 0, 0, 0, (B1<<14), 8'd0, S0, 0, 8'd2};
    do_re(t);
    sb.push_back('{5'd2, 5'd2});
    do_op(0);
    chk("pre_reset_mc", 64'(move_count), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_op_valid", 64'(op_valid), 64'd0);
    chk("midrst_re_ready", 64'(re_ready), 64'd0);
    chk("midrst_mc", 64'(move_count), 64'd0);
    chk("midrst_gp", 64'(games_played), 64'd0);
    chk("midrst_shadow", 64'(dut.shadow_q), 64'(S0));
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
